uart_echo_buffered: RTL

Parametrised successor to the single-byte UART echo path: a buffered echo core between the UART receiver and transmitter byte streams. Received bytes go into an internal FIFO. They are released to the transmitter according to a runtime mode: passthrough, line-buffered or uppercase fold. The block sits in the board top, between uart_rx and uart_tx, in the existing single clock domain.

---
 rtl/uart_echo_pkg.sv | 22 ++
 rtl/uart_echo_buffered_fifo_sync.sv | 61 ++++++
 rtl/uart_echo_buffered.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and helpers for the buffered UART echo core.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        ModePass  = 2'd0,
        ModeLine  = 2'd1,
        ModeUpper = 2'd2
    } mode_e;

    localparam logic [7:0] DefaultTerminator = 8'h0D;

    // Folds ASCII 'a'..'z' to upper case; any other code passes unchanged.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (c >= 8'h61 && c <= 8'h7A) begin
            r[5] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_buffered_fifo_sync.sv
// Show-ahead synchronous FIFO; the head word is valid on data_o whenever empty_o is low.
module fifo_sync #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       push_i,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       pop_i,
    output logic [DataWidth-1:0]       data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int AddrW  = $clog2(Depth);
    localparam int CountW = $clog2(Depth+1);

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrW-1:0]     wr_ptr;
    logic [AddrW-1:0]     rd_ptr;
    logic [CountW-1:0]    count_q;
    logic                 do_push;
    logic                 do_pop;

    // No bypass when full: a push is refused even if a pop frees a slot this cycle.
    assign full_o  = (count_q == CountW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AddrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CountW'(1);
                2'b01:   count_q <= count_q - CountW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_buffered.sv
// Buffered echo core between uart_rx and uart_tx: FIFO plus passthrough, line or upper-case release.
module uart_echo_buffered
    import uart_echo_pkg::*;
#(
    parameter int         DataWidth  = 8,
    parameter int         Depth      = 16,
    parameter logic [7:0] Terminator = DefaultTerminator
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       rx_valid_i,
    input  logic [DataWidth-1:0]       rx_data_i,
    output logic                       rx_ready_o,
    output logic                       tx_valid_o,
    output logic [DataWidth-1:0]       tx_data_o,
    input  logic                       tx_ready_i,
    input  logic [1:0]                 mode_i,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int CountW = $clog2(Depth+1);
    localparam logic [DataWidth-1:0] TermWord = DataWidth'(Terminator);

    mode_e                mode_q;
    mode_e                mode_d;
    logic [CountW-1:0]    pending_lines;
    logic                 flush_q;
    logic [DataWidth-1:0] head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 line_inc;
    logic                 line_dec;
    logic                 force_flush;

    fifo_sync #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push_i   (push),
        .data_i   (rx_data_i),
        .pop_i    (pop),
        .data_o   (head),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count_o)
    );

    assign rx_ready_o = !full;
    assign push       = rx_valid_i && rx_ready_o;
    assign pop        = tx_valid_o && tx_ready_i;

    assign line_inc    = push && (mode_q == ModeLine) && (rx_data_i == TermWord);
    assign line_dec    = pop && (mode_q == ModeLine) && (head == TermWord);
    // A full buffer with no complete line would deadlock, so release it unterminated.
    assign force_flush = (mode_q == ModeLine) && full && (pending_lines == '0) && !flush_q;
    assign overflow_o  = force_flush;

    always_comb begin
        case (mode_i)
            2'd1:    mode_d = ModeLine;
            2'd2:    mode_d = ModeUpper;
            default: mode_d = ModePass;
        endcase
    end

    always_comb begin
        tx_valid_o = !empty;
        if (mode_q == ModeLine) begin
            tx_valid_o = !empty && ((pending_lines != '0) || flush_q);
        end
    end

    // Fold only words whose bits above the low byte are zero.
    always_comb begin
        tx_data_o = head;
        if (mode_q == ModeUpper && (head >> 8) == '0) begin
            tx_data_o[7:0] = to_upper(head[7:0]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            mode_q        <= ModePass;
            pending_lines <= '0;
            flush_q       <= 1'b0;
        end else begin
            // Mode changes only between bursts so a line never straddles two modes.
            if (empty && !push) begin
                mode_q <= mode_d;
            end
            case ({line_inc, line_dec})
                2'b10:   pending_lines <= pending_lines + CountW'(1);
                2'b01:   pending_lines <= pending_lines - CountW'(1);
                default: pending_lines <= pending_lines;
            endcase
            if (force_flush) begin
                flush_q <= 1'b1;
            end else if (empty) begin
                flush_q <= 1'b0;
            end
        end
    end

endmodule
